// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch/data request ports,
// memory-side signals and per-requester responses.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          flush;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          if_grant;
  logic          dm_grant;
  logic          if_valid;
  logic          dm_valid;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] dm_rdata;
  logic [15:0]   stall_count;

  modport master (
    output if_req, if_addr, flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  if_grant, dm_grant,
    input  if_valid, dm_valid,
    input  if_rdata, dm_rdata,
    input  stall_count
  );

  modport slave (
    input  if_req, if_addr, flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output mem_addr, mem_wdata, mem_we,
    output if_grant, dm_grant,
    output if_valid, dm_valid,
    output if_rdata, dm_rdata,
    output stall_count
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port synchronous memory,
// data-first with a fetch starvation guard.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    NONE,
    IF_RD,
    DM_RD,
    DM_WR
  } resp_t;

  resp_t         resp;
  resp_t         resp_nx;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_nx;
  logic [15:0]   stall_cnt;
  logic [15:0]   stall_nx;
  logic          starved;
  logic          if_win;
  logic          dm_win;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          we;

  // Grants are gated by reset so every output reads 0 while held.
  always_comb begin
    starved = (wait_cnt == MAX_W);
    if_win  = !reset && bus.if_req && !bus.flush
              && (starved || !bus.dm_req);
    dm_win  = !reset && bus.dm_req && !if_win;
  end

  always_comb begin
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    unique case (1'b1)
      if_win: begin
        addr  = bus.if_addr;
        wdata = bus.dm_wdata;
      end
      dm_win: begin
        addr  = bus.dm_addr;
        wdata = bus.dm_wdata;
        we    = bus.dm_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    resp_nx = NONE;
    unique case (1'b1)
      if_win:               resp_nx = IF_RD;
      dm_win && !bus.dm_we: resp_nx = DM_RD;
      dm_win && bus.dm_we:  resp_nx = DM_WR;
      default:              resp_nx = NONE;
    endcase
  end

  always_comb begin
    wait_nx = '0;
    if (bus.if_req && !if_win && !bus.flush)
      wait_nx = starved ? wait_cnt : wait_cnt + 4'd1;
  end

  always_comb begin
    stall_nx = stall_cnt;
    if (bus.if_req && !if_win && stall_cnt != 16'hFFFF)
      stall_nx = stall_cnt + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp      <= NONE;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      resp      <= resp_nx;
      wait_cnt  <= wait_nx;
      stall_cnt <= stall_nx;
    end
  end

  assign bus.if_grant    = if_win;
  assign bus.dm_grant    = dm_win;
  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = wdata;
  assign bus.mem_we      = we;
  assign bus.stall_count = stall_cnt;

  // A flush in the response cycle squashes the fetch data.
  assign bus.if_valid = (resp == IF_RD) && !bus.flush;
  assign bus.if_rdata = bus.if_valid ? bus.mem_rdata : '0;
  assign bus.dm_valid = (resp == DM_RD) || (resp == DM_WR);
  assign bus.dm_rdata = (resp == DM_RD) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random
// traffic against a rule-level model of arbitration.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.AW(8), .DW(8)) bus ();
  mem_arbiter_if #(.AW(8), .DW(8)) bus2 ();

  mem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(3)) u1 (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  mem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(15)) u2 (
    .clock(clock),
    .reset(reset),
    .bus(bus2.slave)
  );

  logic [7:0] bmem [256];

  always @(posedge clock) begin
    if (bus.mem_we) bmem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bmem[bus.mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] ref_mem [256];
  int streak;
  int stall;
  int pend_kind;
  logic [7:0] pend_data;
  logic last_if, last_dm, last_flush;

  task automatic model_reset();
    streak = 0;
    stall = 0;
    pend_kind = 0;
    pend_data = 8'h00;
    last_if = 1'b0;
    last_dm = 1'b0;
    last_flush = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0;
    bus.if_addr = 8'h00;
    bus.flush = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_addr = 8'h00;
    bus.dm_wdata = 8'h00;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ifg"}, 32'(bus.if_grant), 0);
    check({tag, "_dmg"}, 32'(bus.dm_grant), 0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 0);
    check({tag, "_wd"}, 32'(bus.mem_wdata), 0);
    check({tag, "_we"}, 32'(bus.mem_we), 0);
    check({tag, "_ifv"}, 32'(bus.if_valid), 0);
    check({tag, "_dmv"}, 32'(bus.dm_valid), 0);
    check({tag, "_ifd"}, 32'(bus.if_rdata), 0);
    check({tag, "_dmd"}, 32'(bus.dm_rdata), 0);
    check({tag, "_stall"}, 32'(bus.stall_count), 0);
  endtask

  // Called just after a falling edge with inputs driven.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("rst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Checks one cycle of u1 against the model, then advances.
  task automatic tick();
    logic ei, ed, ewe, eiv, edv;
    logic [7:0] ea, ewd, eid, edd;
    #1;
    ei = bus.if_req && !bus.flush
         && (!bus.dm_req || streak >= 3);
    ed = bus.dm_req && !ei;
    ea = ei ? bus.if_addr : (ed ? bus.dm_addr : 8'h00);
    ewe = ed && bus.dm_we;
    ewd = (ei || ed) ? bus.dm_wdata : 8'h00;
    eiv = (pend_kind == 1) && !bus.flush;
    eid = eiv ? pend_data : 8'h00;
    edv = (pend_kind >= 2);
    edd = (pend_kind == 2) ? pend_data : 8'h00;
    check("if_grant", 32'(bus.if_grant), 32'(ei));
    check("dm_grant", 32'(bus.dm_grant), 32'(ed));
    check("mem_addr", 32'(bus.mem_addr), 32'(ea));
    check("mem_we", 32'(bus.mem_we), 32'(ewe));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(ewd));
    check("if_valid", 32'(bus.if_valid), 32'(eiv));
    check("if_rdata", 32'(bus.if_rdata), 32'(eid));
    check("dm_valid", 32'(bus.dm_valid), 32'(edv));
    check("dm_rdata", 32'(bus.dm_rdata), 32'(edd));
    check("stall", 32'(bus.stall_count), 32'(stall));
    if (ei) begin
      pend_kind = 1;
      pend_data = ref_mem[bus.if_addr];
    end else if (ed) begin
      pend_kind = bus.dm_we ? 3 : 2;
      pend_data = ref_mem[bus.dm_addr];
    end else begin
      pend_kind = 0;
    end
    if (ewe) ref_mem[bus.dm_addr] = bus.dm_wdata;
    if (bus.if_req && !ei && !bus.flush) streak++;
    else streak = 0;
    if (bus.if_req && !ei && stall < 65535) stall++;
    last_if = ei;
    last_dm = ed;
    last_flush = bus.flush;
    @(negedge clock);
  endtask

  initial begin
    logic pat [6];
    logic fetch_win;
    int s2;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 8'($urandom);
      ref_mem[i] = bmem[i];
    end
    bmem[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    idle_inputs();
    bus2.if_req = 1'b0;
    bus2.if_addr = 8'h44;
    bus2.flush = 1'b0;
    bus2.dm_req = 1'b0;
    bus2.dm_we = 1'b0;
    bus2.dm_addr = 8'h55;
    bus2.dm_wdata = 8'h00;
    bus2.mem_rdata = 8'h00;
    @(negedge clock);
    do_reset();

    // fetch only
    bus.if_req = 1'b1;
    bus.if_addr = 8'h10;
    #1 check("s1_grant", 32'(bus.if_grant), 1);
    tick();
    idle_inputs();
    #1 check("s1_valid", 32'(bus.if_valid), 1);
    check("s1_rdata", 32'(bus.if_rdata), 32'hA5);
    tick();

    // both held six cycles, loads
    do_reset();
    pat = '{0, 0, 0, 1, 0, 0};
    bus.if_req = 1'b1;
    bus.if_addr = 8'h33;
    bus.dm_req = 1'b1;
    bus.dm_addr = 8'h34;
    for (int c = 0; c < 6; c++) begin
      #1 check("s2_ifg", 32'(bus.if_grant), 32'(pat[c]));
      check("s2_dmg", 32'(bus.dm_grant), 32'(!pat[c]));
      if (c == 4) check("s2_stall", 32'(bus.stall_count), 3);
      tick();
    end
    idle_inputs();
    tick();

    // store
    do_reset();
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_addr = 8'h20;
    bus.dm_wdata = 8'h3C;
    #1 check("s3_we", 32'(bus.mem_we), 1);
    check("s3_addr", 32'(bus.mem_addr), 32'h20);
    check("s3_wd", 32'(bus.mem_wdata), 32'h3C);
    tick();
    idle_inputs();
    #1 check("s3_dmv", 32'(bus.dm_valid), 1);
    check("s3_dmd", 32'(bus.dm_rdata), 0);
    tick();

    // fetch granted, flush in the response cycle
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 8'h50;
    tick();
    bus.flush = 1'b1;
    bus.if_addr = 8'h60;
    #1 check("s4_ifv", 32'(bus.if_valid), 0);
    check("s4_ifg", 32'(bus.if_grant), 0);
    tick();
    idle_inputs();
    #1 check("s4_wait", 32'(u1.wait_cnt), 0);
    tick();

    // reset in the middle of a load
    bus.dm_req = 1'b1;
    bus.dm_addr = 8'h70;
    #1 check("s5_dmg", 32'(bus.dm_grant), 1);
    #1 reset = 1'b1;
    #1 check_zero("s5");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle_inputs();
    #1 check("s5_dmv", 32'(bus.dm_valid), 0);
    tick();
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!bus.if_req || last_if || last_flush) begin
        bus.if_req = 1'($urandom);
        bus.if_addr = 8'($urandom);
      end
      if (!bus.dm_req || last_dm) begin
        bus.dm_req = ($urandom_range(0, 3) != 0);
        bus.dm_we = 1'($urandom);
        bus.dm_addr = 8'($urandom);
        bus.dm_wdata = 8'($urandom);
      end
      bus.flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
    tick();

    // long starvation run on the MAX_WAIT=15 instance
    do_reset();
    bus2.if_req = 1'b1;
    bus2.dm_req = 1'b1;
    s2 = 0;
    for (int n = 0; n < 70000; n++) begin
      fetch_win = (n % 16 == 15);
      #1 check("l_ifg", 32'(bus2.if_grant), 32'(fetch_win));
      check("l_dmg", 32'(bus2.dm_grant), 32'(!fetch_win));
      check("l_stall", 32'(bus2.stall_count), 32'(s2));
      if (!fetch_win && s2 < 65535) s2++;
      @(negedge clock);
    end
    #1 check("l_sat", 32'(bus2.stall_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be AW, default 8, address width; DW, default 8, data width; MAX_WAIT, default 3, fetch starvation limit in cycles (1..15).
REQ-002 Ports SHALL be as follows:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous, active-high
  if_req  in  1  fetch stage read request
  if_addr  in  AW  fetch address
  flush  in  1  taken branch; squash fetch traffic
  dm_req  in  1  data stage request
  dm_we  in  1  1 = store, 0 = load
  dm_addr  in  AW  data address
  dm_wdata  in  DW  store data
  mem_rdata  in  DW  shared memory read data (valid one cycle after address)
  mem_addr  out  AW  shared memory address
  mem_wdata  out  DW  shared memory write data
  mem_we  out  1  shared memory write enable
  if_grant, dm_grant  out  1  request accepted this cycle
  if_valid, dm_valid  out  1  response/ack this cycle
  if_rdata, dm_rdata  out  DW  read data, meaningful only when the matching valid is 1
  stall_count  out  16  cycles in which fetch was denied
REQ-003 Reset SHALL be asynchronous and active-high on port reset; the block SHALL use the single clock clock.

Function
REQ-004 The block SHALL own one single-port synchronous memory shared by fetch and data requesters, and SHALL grant at most one requester per cycle.
REQ-005 Grants SHALL be combinational from the current requests, flush, and the registered wait counter.
REQ-006 Default priority SHALL be data over fetch.
REQ-007 If wait_cnt == MAX_WAIT and if_req=1 and flush=0, fetch SHALL win over data.
REQ-008 if_grant SHALL be 0 whenever flush=1.
REQ-009 In a granted cycle, mem_addr SHALL be the winner's address, with mem_we = dm_grant & dm_we and mem_wdata = dm_wdata.
REQ-010 In an idle cycle, mem_addr, mem_wdata and mem_we SHALL be 0.
REQ-011 The registered response state resp SHALL be one of NONE, IF_RD, DM_RD, DM_WR.
REQ-012 resp SHALL be loaded every cycle:
  IF_RD if if_grant;
  DM_RD if dm_grant & !dm_we;
  DM_WR if dm_grant & dm_we;
  otherwise NONE.
REQ-013 if_valid SHALL be (resp==IF_RD) & !flush, with if_rdata = mem_rdata. A flush in the response cycle SHALL squash the fetch response.
REQ-014 dm_valid SHALL be resp==DM_RD or resp==DM_WR.
REQ-015 dm_rdata SHALL equal mem_rdata for DM_RD and 0 for DM_WR.
REQ-016 The latency from grant to valid SHALL be exactly 1 cycle, with back-to-back grants permitted every cycle.
REQ-017 wait_cnt (4-bit) SHALL increment, saturating at MAX_WAIT, each cycle if_req=1 & if_grant=0 & flush=0.
REQ-018 wait_cnt SHALL clear on if_grant, on if_req=0, or on flush.
REQ-019 stall_count SHALL increment each cycle if_req=1 & if_grant=0, saturating at 16'hFFFF, and SHALL never wrap.
REQ-020 Requesters SHALL hold req and address stable until granted; the block SHALL NOT queue requests.

Reset
REQ-021 While reset=1, all outputs SHALL be 0, resp SHALL be NONE, wait_cnt SHALL be 0 and stall_count SHALL be 0.
REQ-022 An outstanding response at reset assertion SHALL be dropped, with no valid pulse after reset release.
REQ-023 In the first cycle after reset release, requests SHALL be arbitrated normally.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
  - Fetch only, if_addr=8'h10, mem_rdata=8'hA5 next cycle -> if_grant in cycle 0, if_valid=1 with if_rdata=8'hA5 in cycle 1.
  - if_req and dm_req held 6 cycles, loads, MAX_WAIT=3 -> dm_grant in cycles 0-2, if_grant in cycle 3, dm_grant in cycle 4; stall_count=3.
  - Store, dm_addr=8'h20, dm_wdata=8'h3C -> mem_we=1, mem_addr=8'h20, mem_wdata=8'h3C in cycle 0; dm_valid=1, dm_rdata=0 in cycle 1.
  - Fetch granted in cycle 0, flush=1 in cycle 1 -> if_valid=0 in cycle 1, if_grant=0 in cycle 1, wait_cnt=0.
  - Load granted, reset asserted mid-cycle before the response -> all outputs 0 immediately, no dm_valid after release.
  - if_req held 70000 cycles with dm_req=1 always, MAX_WAIT=15 -> stall_count saturates at 16'hFFFF, fetch granted every 16th cycle.
